spi_rx_ctrl: RTL and testbench
==============================

SPI_RX_CTRL -- requirements
Module: spi_rx_ctrl

Interface
REQ-001 Parameter: DATA_W, default 24, bits per captured word (>=2).
REQ-002 Parameter: FIFO_DEPTH, default 4, captured-word buffer depth, power of two, >=2.
REQ-003 Parameter: MSB_FIRST, default 1, 1 = first serial bit lands in bit DATA_W-1, 0 = first bit lands in bit 0.
REQ-004 Parameter: NUM_OP, default 2, number of operation-strobe channels (bit0 = ALU, bit1 = MAC).
REQ-005 spi_clk  in  1  sole clock, all logic on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 spi_en  in  1  frame select, active low.
REQ-008 spi_sdi  in  1  serial data, sampled on posedge spi_clk while spi_en low.
REQ-009 op_st  in  NUM_OP  operation start requests.
REQ-010 rd_en  in  1  pop FIFO head.
REQ-011 err_clr  in  1  clears sticky error flags.
REQ-012 spi_out  out  DATA_W  FIFO head word, show-ahead.
REQ-013 out_valid  out  1  FIFO not empty.
REQ-014 fifo_cnt  out  clog2(FIFO_DEPTH)+1  words held.
REQ-015 cap_en  out  1  one-cycle pulse per completed word.
REQ-016 op_en  out  NUM_OP  registered op_st.
REQ-017 frame_err  out  1  sticky, partial word discarded.
REQ-018 ovf  out  1  sticky, word dropped on full FIFO.

Function
REQ-019 FSM states SYNC, IDLE, SHIFT; SYNC -> IDLE when spi_en high; IDLE -> SHIFT when spi_en low (that edge samples bit 0); SHIFT -> IDLE when spi_en high.
REQ-020 SYNC ignores spi_sdi, so a frame already active at reset release is never captured.
REQ-021 Each sampled bit is written at index cnt (MSB_FIRST=0) or DATA_W-1-cnt (MSB_FIRST=1); cnt increments per sample.
REQ-022 On the edge sampling bit DATA_W-1: the assembled word is pushed, cnt wraps to 0, cap_en is 1 for exactly the following cycle, FSM stays in SHIFT, and back-to-back words in one frame are captured without gaps.
REQ-023 spi_out/out_valid reflect a pushed word in the cycle after the last-bit edge when the FIFO was empty (latency 1 from last bit).
REQ-024 spi_en rising with cnt != 0: partial word discarded, no push, cnt cleared, frame_err set; cnt == 0: no error.
REQ-025 Push on full without simultaneous rd_en: word dropped, FIFO unchanged, ovf set, cap_en still pulses.
REQ-026 Push and rd_en together on full: both occur, no ovf, fifo_cnt unchanged.
REQ-027 rd_en on empty: ignored, no flag.
REQ-028 err_clr clears frame_err and ovf next cycle; a same-cycle set event wins over err_clr.
REQ-029 op_en = op_st delayed one cycle, independent of FSM.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH.

Reset
REQ-031 rst asserted: FSM = SYNC, cnt = 0, shift register = 0, FIFO empty, spi_out = 0, out_valid = 0, fifo_cnt = 0, cap_en = 0, op_en = 0, frame_err = 0, ovf = 0, immediately without a clock.
REQ-032 Reset mid-frame discards the partial word and sets no error flag.

Structure
REQ-033 Package spi_rx_pkg holds the FSM state enum (SYNC, IDLE, SHIFT) and default parameter constants.
REQ-034 FIFO is sub-module spi_rx_fifo (DATA_W, FIFO_DEPTH; push, pop, head, count, full, empty); spi_rx_ctrl holds FSM, shifter, flags, op_en.

Verification
REQ-035 Defaults, frame of 24 bits 0xA5C3F0 MSB first -> cap_en one pulse after bit 23, spi_out = 0xA5C3F0, fifo_cnt = 1.
REQ-036 MSB_FIRST=0, 24 bits of 0xA5C3F0 sent LSB first -> spi_out = 0xA5C3F0; one frame of 48 bits -> two words, two cap_en pulses 24 cycles apart.
REQ-037 Frame of 10 bits then spi_en high -> frame_err = 1, fifo_cnt = 0, no cap_en; err_clr -> frame_err = 0.
REQ-038 Five words 0x000001..0x000005, no rd_en, depth 4 -> ovf = 1, fifo_cnt = 4; four pops yield 0x000001..0x000004.
REQ-039 rst pulse at bit 12 with spi_en held low, 30 more bits, then spi_en high and a new 24-bit frame of 0x123456 -> only 0x123456 captured, no flags.
REQ-040 op_st = 2'b10 for one cycle -> op_en = 2'b10 exactly one cycle later, for one cycle.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and default parameters for the SPI receive controller.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } rx_state_e;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MSB_FIRST  = 1;
  localparam int DEF_NUM_OP     = 2;

endpackage

// File: rtl/spi_rx_ctrl_if.sv
// Bundle of serial input, FIFO read side, op strobes and status flags.
interface spi_rx_ctrl_if
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int NUM_OP     = DEF_NUM_OP
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              spi_en;
  logic              spi_sdi;
  logic [NUM_OP-1:0] op_st;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] spi_out;
  logic              out_valid;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              cap_en;
  logic [NUM_OP-1:0] op_en;
  logic              frame_err;
  logic              ovf;

  modport master (
    output spi_en, spi_sdi, op_st, rd_en, err_clr,
    input  spi_out, out_valid, fifo_cnt, cap_en, op_en, frame_err, ovf
  );

  modport slave (
    input  spi_en, spi_sdi, op_st, rd_en, err_clr,
    output spi_out, out_valid, fifo_cnt, cap_en, op_en, frame_err, ovf
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Show-ahead word FIFO; a push on full succeeds only when a pop happens in the same cycle.
module spi_rx_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign count = count_q;
  // Head is forced to zero when empty so stale storage never shows on the output.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_rx_ctrl.sv
// SPI frame receiver: deserialises spi_sdi into DATA_W-bit words, buffers them
// in a FIFO, and keeps sticky framing/overflow flags plus registered op strobes.
module spi_rx_ctrl
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MSB_FIRST  = DEF_MSB_FIRST,
  parameter int NUM_OP     = DEF_NUM_OP
) (
  input logic           spi_clk,
  input logic           rst,
  spi_rx_ctrl_if.slave  bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cap_en_q, cap_en_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_q, ovf_d;
  logic [NUM_OP-1:0] op_en_q, op_en_d;

  logic [DATA_W-1:0] word_nxt;
  logic [BW-1:0]     bit_idx;
  logic              sample;
  logic              push;
  logic              frame_set;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Frame FSM, bit placement, word completion and sticky flag updates.
  // SYNC waits for spi_en high so a frame already running at reset release is skipped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    cap_en_d  = 1'b0;
    sample    = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    op_en_d   = bus.op_st;

    bit_idx  = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;
    word_nxt = shreg_q;
    word_nxt[bit_idx] = bus.spi_sdi;

    case (state_q)
      SYNC: begin
        if (bus.spi_en) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.spi_en) begin
          state_d = SHIFT;
          sample  = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.spi_en) begin
          state_d   = IDLE;
          cnt_d     = '0;
          shreg_d   = '0;
          frame_set = (cnt_q != '0);
        end else begin
          sample = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    if (sample) begin
      if (cnt_q == LAST_IDX) begin
        push     = 1'b1;
        cnt_d    = '0;
        shreg_d  = '0;
        cap_en_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + BW'(1);
        shreg_d = word_nxt;
      end
    end

    // A read in the same cycle frees the slot, so only a read-less push on full drops.
    ovf_set = push & fifo_full & ~bus.rd_en;

    frame_err_d = frame_set ? 1'b1 : (bus.err_clr ? 1'b0 : frame_err_q);
    ovf_d       = ovf_set   ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
  end

  // All controller state and registered outputs.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      shreg_q     <= '0;
      cap_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      op_en_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      cap_en_q    <= cap_en_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      op_en_q     <= op_en_d;
    end
  end

  spi_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (spi_clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_nxt),
    .pop       (bus.rd_en),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.spi_out   = fifo_head;
  assign bus.out_valid = ~fifo_empty;
  assign bus.fifo_cnt  = fifo_count;
  assign bus.cap_en    = cap_en_q;
  assign bus.op_en     = op_en_q;
  assign bus.frame_err = frame_err_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Bench for spi_rx_ctrl: expected FIFO words go into per-DUT queues and a
// read monitor pops and compares on every accepted rd_en.
module tb_spi_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] en_v, sdi_v, rd_v, clr_v;
  logic [1:0] op0, op1;

  spi_rx_ctrl_if #(.DATA_W(24), .FIFO_DEPTH(4), .NUM_OP(2)) b0 ();
  spi_rx_ctrl_if #(.DATA_W(24), .FIFO_DEPTH(4), .NUM_OP(2)) b1 ();

  assign b0.spi_en  = en_v[0];
  assign b0.spi_sdi = sdi_v[0];
  assign b0.rd_en   = rd_v[0];
  assign b0.err_clr = clr_v[0];
  assign b0.op_st   = op0;
  assign b1.spi_en  = en_v[1];
  assign b1.spi_sdi = sdi_v[1];
  assign b1.rd_en   = rd_v[1];
  assign b1.err_clr = clr_v[1];
  assign b1.op_st   = op1;

  spi_rx_ctrl #(.DATA_W(24), .FIFO_DEPTH(4), .MSB_FIRST(1), .NUM_OP(2)) u0 (
    .spi_clk (clk),
    .rst     (rst),
    .bus     (b0)
  );

  spi_rx_ctrl #(.DATA_W(24), .FIFO_DEPTH(4), .MSB_FIRST(0), .NUM_OP(2)) u1 (
    .spi_clk (clk),
    .rst     (rst),
    .bus     (b1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int cap0 = 0;
  int cap1 = 0;
  int cyc_n = 0;
  int cap1_t[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Read monitors: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rd_v[0] && b0.out_valid) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL rd0_unexpected: got word 0x%0h expected no word", b0.spi_out);
      end else check("rd0_word", 32'(b0.spi_out), 32'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_v[1] && b1.out_valid) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL rd1_unexpected: got word 0x%0h expected no word", b1.spi_out);
      end else check("rd1_word", 32'(b1.spi_out), 32'(q1.pop_front()));
    end
  end

  // Capture pulse counters with cycle stamps.
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (b0.cap_en) cap0++;
    if (b1.cap_en) begin
      cap1++;
      cap1_t.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(int d, logic b);
    en_v[d]  = 1'b0;
    sdi_v[d] = b;
    cyc();
  endtask

  task automatic send_word(int d, logic [23:0] w, bit msb, bit pop_last);
    for (int i = 0; i < 24; i++) begin
      if (pop_last && i == 23) rd_v[d] = 1'b1;
      send_bit(d, msb ? w[23-i] : w[i]);
    end
    rd_v[d] = 1'b0;
  endtask

  task automatic frame_end(int d);
    en_v[d] = 1'b1;
    cyc();
  endtask

  task automatic pop_n(int d, int n);
    rd_v[d] = 1'b1;
    repeat (n) cyc();
    rd_v[d] = 1'b0;
  endtask

  task automatic clear_err(int d);
    clr_v[d] = 1'b1;
    cyc();
    clr_v[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w1, w2;
    en_v = 2'b11; sdi_v = '0; rd_v = '0; clr_v = '0; op0 = '0; op1 = '0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_spi_out", 32'(b0.spi_out), 32'h0);
    check("rst_fifo_cnt", 32'(b0.fifo_cnt), 32'h0);
    check("rst_flags", 32'({b0.out_valid, b0.cap_en, b0.frame_err, b0.ovf, b0.op_en}), 32'h0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc(); cyc();

    // Default MSB-first word.
    w1 = 24'hA5C3F0;
    q0.push_back(w1);
    for (int i = 0; i < 23; i++) send_bit(0, w1[23-i]);
    check("cap_before_last", 32'(b0.cap_en), 32'h0);
    check("valid_before_last", 32'(b0.out_valid), 32'h0);
    send_bit(0, w1[0]);
    check("cap_after_last", 32'(b0.cap_en), 32'h1);
    check("msb_word_head", 32'(b0.spi_out), 32'hA5C3F0);
    check("msb_word_cnt", 32'(b0.fifo_cnt), 32'h1);
    frame_end(0);
    check("cap_one_cycle", 32'(b0.cap_en), 32'h0);
    check("cap_count_1", 32'(cap0), 32'd1);
    check("clean_frame_no_err", 32'(b0.frame_err), 32'h0);
    pop_n(0, 1);
    check("pop_to_empty", 32'(b0.fifo_cnt), 32'h0);

    // Short frame raises frame_err; err_clr clears it; set beats clear.
    for (int i = 0; i < 10; i++) send_bit(0, 1'(i));
    frame_end(0);
    check("short_frame_err", 32'(b0.frame_err), 32'h1);
    check("short_frame_cnt", 32'(b0.fifo_cnt), 32'h0);
    check("short_frame_nocap", 32'(cap0), 32'd1);
    clear_err(0);
    check("err_clr_frame", 32'(b0.frame_err), 32'h0);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    clr_v[0] = 1'b1;
    frame_end(0);
    clr_v[0] = 1'b0;
    check("set_beats_clr", 32'(b0.frame_err), 32'h1);
    clear_err(0);
    check("err_clr_again", 32'(b0.frame_err), 32'h0);

    // Overflow: five words into depth 4 with no reads.
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q0.push_back(24'(k));
      send_word(0, 24'(k), 1'b1, 1'b0);
      frame_end(0);
    end
    check("ovf_set", 32'(b0.ovf), 32'h1);
    check("ovf_cnt_full", 32'(b0.fifo_cnt), 32'h4);
    check("ovf_cap_count", 32'(cap0), 32'd6);
    pop_n(0, 4);
    check("drain_cnt", 32'(b0.fifo_cnt), 32'h0);
    check("drain_valid", 32'(b0.out_valid), 32'h0);
    pop_n(0, 1);
    check("pop_empty_cnt", 32'(b0.fifo_cnt), 32'h0);
    check("pop_empty_flags", 32'({b0.ovf, b0.frame_err}), 32'h2);
    clear_err(0);
    check("err_clr_ovf", 32'(b0.ovf), 32'h0);

    // Push and pop together on a full FIFO.
    for (int k = 0; k < 4; k++) begin
      q0.push_back(24'h11 + 24'(k));
      send_word(0, 24'h11 + 24'(k), 1'b1, 1'b0);
      frame_end(0);
    end
    q0.push_back(24'h15);
    send_word(0, 24'h15, 1'b1, 1'b1);
    check("full_pushpop_cnt", 32'(b0.fifo_cnt), 32'h4);
    check("full_pushpop_no_ovf", 32'(b0.ovf), 32'h0);
    frame_end(0);
    pop_n(0, 4);
    check("full_pushpop_drain", 32'(b0.fifo_cnt), 32'h0);

    // Reset mid-frame, frame continues through SYNC, then a clean frame.
    for (int i = 0; i < 12; i++) send_bit(0, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_cap", 32'({b0.cap_en, b0.frame_err, b0.ovf, b0.out_valid}), 32'h0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) send_bit(0, 1'(i));
    frame_end(0);
    check("midrst_no_frame_err", 32'(b0.frame_err), 32'h0);
    check("midrst_no_capture", 32'(b0.fifo_cnt), 32'h0);
    q0.push_back(24'h123456);
    send_word(0, 24'h123456, 1'b1, 1'b0);
    frame_end(0);
    check("midrst_word", 32'(b0.spi_out), 32'h123456);
    check("midrst_cnt", 32'(b0.fifo_cnt), 32'h1);
    check("midrst_flags", 32'({b0.frame_err, b0.ovf}), 32'h0);
    check("midrst_cap_count", 32'(cap0), 32'd12);
    pop_n(0, 1);

    // Op strobe delay.
    check("op_idle", 32'(b0.op_en), 32'h0);
    op0 = 2'b10;
    cyc();
    op0 = 2'b00;
    check("op_delayed", 32'(b0.op_en), 32'h2);
    cyc();
    check("op_one_cycle", 32'(b0.op_en), 32'h0);

    // LSB-first instance.
    q1.push_back(24'hA5C3F0);
    send_word(1, 24'hA5C3F0, 1'b0, 1'b0);
    check("lsb_word_head", 32'(b1.spi_out), 32'hA5C3F0);
    check("lsb_word_cnt", 32'(b1.fifo_cnt), 32'h1);
    frame_end(1);
    pop_n(1, 1);
    w1 = 24'h123456;
    w2 = 24'hABCDEF;
    q1.push_back(w1);
    q1.push_back(w2);
    for (int i = 0; i < 48; i++) send_bit(1, (i < 24) ? w1[i] : w2[i-24]);
    frame_end(1);
    check("two_word_cnt", 32'(b1.fifo_cnt), 32'h2);
    check("two_word_no_err", 32'(b1.frame_err), 32'h0);
    check("two_word_caps", 32'(cap1), 32'd3);
    if (cap1_t.size() >= 3)
      check("two_word_spacing", 32'(cap1_t[2] - cap1_t[1]), 32'd24);
    else begin
      n_chk++;
      $display("FAIL two_word_spacing: got %0d pulses expected 3", cap1_t.size());
    end
    pop_n(1, 2);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
